// File: rtl/accumulator_file.sv
// Accumulator register file: REGISTER_DEPTH rows of MATRIX_WIDTH signed lanes, each row overwritten or accumulated per lane under a write mask.
// Latency: a write commits two enabled edges after acceptance, and a read returns data one enabled edge after read_addr is sampled.
// Backpressure: writes are dropped while busy (clear drain/sweep), and enable low freezes all state. Defining ACC_SATURATE_EN selects saturating adds.
module accumulator_file #(
  parameter int MATRIX_WIDTH   = 8,
  parameter int REGISTER_DEPTH = 512,
  parameter int DATA_WIDTH     = 32,
  localparam int ADDR_W = (REGISTER_DEPTH > 1) ? $clog2(REGISTER_DEPTH) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   enable,
  input  logic                                   write_enable,
  input  logic [ADDR_W-1:0]                      write_addr,
  input  logic [MATRIX_WIDTH-1:0]                write_mask,
  input  logic                                   accumulate,
  input  logic [MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_W-1:0]                      read_addr,
  output logic [MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] data_out,
  input  logic                                   clear,
  output logic                                   busy,
  output logic [MATRIX_WIDTH-1:0]                overflow
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_SWEEP} state_t;

  logic [MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] mem [REGISTER_DEPTH];

  // Stage 1: accepted write request
  logic                                   s1_vld;
  logic [ADDR_W-1:0]                      s1_addr;
  logic [MATRIX_WIDTH-1:0]                s1_mask;
  logic                                   s1_acc;
  logic [MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] s1_data;

  // Stage 2: computed row waiting to commit
  logic                                   s2_vld;
  logic [ADDR_W-1:0]                      s2_addr;
  logic [MATRIX_WIDTH-1:0]                s2_mask;
  logic [MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] s2_data;

  logic                                   fwd_hit;
  logic [DATA_WIDTH-1:0]                  old_lane;
  logic [MATRIX_WIDTH-1:0][DATA_WIDTH-1:0] s1_result;

`ifdef ACC_SATURATE_EN
  logic [DATA_WIDTH:0]                    wide;
  logic [MATRIX_WIDTH-1:0]                s1_ovf;
  logic [MATRIX_WIDTH-1:0]                s2_ovf;
`endif

  state_t                                 state;
  logic                                   drain_cnt;
  logic [ADDR_W-1:0]                      sweep_addr;

  logic accept_wr;
  logic commit;
  logic sweep_wr;
  logic sweep_start;

  assign accept_wr   = enable && write_enable && !busy;
  assign commit      = enable && s2_vld;
  assign sweep_wr    = enable && (state == ST_SWEEP);
  assign sweep_start = enable && (state == ST_DRAIN) && drain_cnt;

  // Per-lane new value; the old operand comes from S2 when it targets the same row so back-to-back accumulates see uncommitted data
  always_comb begin
    fwd_hit   = s2_vld && (s2_addr == s1_addr);
    s1_result = s1_data;
    old_lane  = '0;
`ifdef ACC_SATURATE_EN
    s1_ovf    = '0;
    wide      = '0;
`endif
    for (int l = 0; l < MATRIX_WIDTH; l++) begin
      old_lane = (fwd_hit && s2_mask[l]) ? s2_data[l] : mem[s1_addr][l];
`ifdef ACC_SATURATE_EN
      wide = {old_lane[DATA_WIDTH-1], old_lane} + {s1_data[l][DATA_WIDTH-1], s1_data[l]};
      if (s1_acc) begin
        if (wide[DATA_WIDTH] != wide[DATA_WIDTH-1]) begin
          s1_ovf[l]    = 1'b1;
          s1_result[l] = wide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                          : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
          s1_result[l] = wide[DATA_WIDTH-1:0];
        end
      end
`else
      if (s1_acc) s1_result[l] = old_lane + s1_data[l];
`endif
    end
  end

  // Write pipeline registers S1 and S2, frozen while enable is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_addr <= '0;
      s1_mask <= '0;
      s1_acc  <= 1'b0;
      s1_data <= '0;
      s2_vld  <= 1'b0;
      s2_addr <= '0;
      s2_mask <= '0;
      s2_data <= '0;
`ifdef ACC_SATURATE_EN
      s2_ovf  <= '0;
`endif
    end else if (enable) begin
      s1_vld <= accept_wr;
      if (accept_wr) begin
        s1_addr <= write_addr;
        s1_mask <= write_mask;
        s1_acc  <= accumulate;
        s1_data <= data_in;
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_addr <= s1_addr;
        s2_mask <= s1_mask;
        s2_data <= s1_result;
`ifdef ACC_SATURATE_EN
        s2_ovf  <= s1_ovf;
`endif
      end
    end
  end

  // Clear sequencer: two drain cycles empty the pipeline, then one row is zeroed per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      drain_cnt  <= 1'b0;
      sweep_addr <= '0;
    end else if (enable) begin
      case (state)
        ST_IDLE: begin
          if (clear) begin
            state     <= ST_DRAIN;
            busy      <= 1'b1;
            drain_cnt <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt) begin
            state      <= ST_SWEEP;
            sweep_addr <= '0;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        ST_SWEEP: begin
          if (sweep_addr == ADDR_W'(REGISTER_DEPTH - 1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            sweep_addr <= sweep_addr + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Row storage: sweep zeroing or masked-lane commit from S2 (never both, the pipeline is empty during sweep)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < REGISTER_DEPTH; r++) mem[r] <= '0;
    end else if (sweep_wr) begin
      mem[sweep_addr] <= '0;
    end else if (commit) begin
      for (int l = 0; l < MATRIX_WIDTH; l++) begin
        if (s2_mask[l]) mem[s2_addr][l] <= s2_data[l];
      end
    end
  end

  // Registered read of committed storage; pipeline contents are not forwarded
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (enable) begin
      data_out <= mem[read_addr];
    end
  end

`ifdef ACC_SATURATE_EN
  // Sticky per-lane clamp flags, raised when a clamped lane commits and wiped when the sweep begins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= '0;
    end else if (sweep_start) begin
      overflow <= '0;
    end else if (commit) begin
      overflow <= overflow | (s2_mask & s2_ovf);
    end
  end
`else
  assign overflow = '0;
`endif

endmodule

// File: doc/accumulator_file.md
ACCUMULATOR_FILE -- requirements
Module: accumulator_file

Interface
REQ-001 Parameter MATRIX_WIDTH, default 8, number of lanes per row.
REQ-002 Parameter REGISTER_DEPTH, default 512, number of rows; address width ADDR_W = clog2(REGISTER_DEPTH).
REQ-003 Parameter DATA_WIDTH, default 32, lane width in bits, two's complement.
REQ-004 Port clk  input  1  sole clock, all state on rising edge.
REQ-005 Port rst  input  1  asynchronous, active-high reset.
REQ-006 Port enable  input  1  global advance; low freezes all state.
REQ-007 Port write_enable  input  1  write request this cycle.
REQ-008 Port write_addr  input  ADDR_W  target row.
REQ-009 Port write_mask  input  MATRIX_WIDTH  per-lane write qualifier.
REQ-010 Port accumulate  input  1  1: add data_in to stored row; 0: overwrite.
REQ-011 Port data_in  input  MATRIX_WIDTH x DATA_WIDTH  write data.
REQ-012 Port read_addr  input  ADDR_W  read row.
REQ-013 Port data_out  output  MATRIX_WIDTH x DATA_WIDTH  registered read data.
REQ-014 Port clear  input  1  request zeroing of all rows.
REQ-015 Port busy  output  1  high while a clear is draining or sweeping.
REQ-016 Port overflow  output  MATRIX_WIDTH  sticky per-lane saturation flag.

Function
REQ-017 Write accepted at edge N when enable & write_enable & !busy; captured into stage S1; else dropped.
REQ-018 S1 computes per lane: accumulate ? old+data_in : data_in; result registered into S2 at edge N+1.
REQ-019 S2 commits masked lanes to memory at edge N+2; unmasked lanes keep prior value.
REQ-020 Forwarding: if S2 valid and S2 addr == S1 addr, S1 uses S2 merged row as old value; back-to-back accumulates to one row SHALL be exact.
REQ-021 Read: read_addr sampled at edge when enable high; data_out shows committed memory row after that edge (1-cycle latency, no forwarding from S1/S2).
REQ-022 Arithmetic wraps modulo 2^DATA_WIDTH unless ACC_SATURATE_EN defined.
REQ-023 enable low: S1, S2, FSM, data_out, memory hold; no commit; clear request ignored.
REQ-024 Clear FSM: IDLE -> DRAIN on enable & clear & !busy; DRAIN 2 cycles (S1, S2 commit); SWEEP writes zero to rows 0..REGISTER_DEPTH-1, one per cycle; -> IDLE after last row.
REQ-025 busy high in DRAIN and SWEEP; writes presented while busy are dropped, reads remain serviced.
REQ-026 clear asserted while busy is ignored; clear and write_enable in the same IDLE cycle: write accepted, then drained.
REQ-027 Sweep also clears overflow flags on entering SWEEP.

Reset
REQ-028 rst high asynchronously: all memory rows, S1/S2 valid, data_out, overflow to zero; FSM to IDLE; busy 0.
REQ-029 rst mid-sweep or mid-pipeline aborts the operation; no partial commit after release.

Configuration
REQ-030 Macro ACC_SATURATE_EN defined: signed saturating add per lane, clamp to max/min, set overflow[lane] on clamp (sticky until reset or clear).
REQ-031 Macro ACC_SATURATE_EN undefined: wrap-around add, overflow tied to zero.

Verification (MATRIX_WIDTH=4, REGISTER_DEPTH=8, DATA_WIDTH=32)
REQ-032 Overwrite row i with all lanes = i, i=0..7, read each -> data_out lanes = i one cycle after read_addr.
REQ-033 Preload row 3 = 5, four consecutive accumulates of data_in lane j = j to row 3 -> row 3 reads 5+4j.
REQ-034 Overwrite row 2 = 7 with mask 4'b0101, data_in = 1 -> lanes {1,7,1,7} (lane0 first).
REQ-035 Rows loaded, clear pulse -> busy high 10 cycles (2 drain + 8 sweep), write during busy dropped, all rows read 0 afterwards.
REQ-036 ACC_SATURATE_EN: row 0 = 0x7FFFFFF0, accumulate 0x20 -> 0x7FFFFFFF, overflow = 4'b1111; without macro -> 0x80000010, overflow 0.
REQ-037 enable low for 3 cycles with write in S1 -> commit delayed 3 cycles; rst mid-sweep -> all rows 0, busy 0.
